// File: rtl/priority_encoder_pkg.sv
// Shared types and helpers for the priority encoder family.
package priority_encoder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } pe_state_t;

   // Width of a field addressing n items, never narrower than one bit.
   function automatic int unsigned pos_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/priority_encoder_seq_slice_prio.sv
// Combinational highest/lowest set-bit finder for one SLICE-bit slice.
module slice_prio
   import priority_encoder_pkg::*;
#(
   parameter  int unsigned SLICE = 4,
   localparam int unsigned PW    = pos_w(SLICE)
) (
   input  logic [SLICE-1:0] slice_i,
   output logic             any_o,
   output logic [PW-1:0]    hi_pos_o,
   output logic [PW-1:0]    lo_pos_o
);

   always_comb begin
      any_o    = |slice_i;
      hi_pos_o = '0;
      lo_pos_o = '0;
      // Ascending sweep for hi and descending for lo: the last hit wins in each.
      for (int unsigned i = 0; i < SLICE; i++) begin
         if (slice_i[i])
            hi_pos_o = PW'(i);
         if (slice_i[SLICE-1-i])
            lo_pos_o = PW'(SLICE-1-i);
      end
   end

endmodule

// File: rtl/priority_encoder_seq.sv
// Multi-cycle leftmost/rightmost set-bit encoder scanning one slice per clock.
module priority_encoder_seq
   import priority_encoder_pkg::*;
#(
   parameter  int unsigned WIDTH = 16,
   parameter  int unsigned SLICE = 4,
   localparam int unsigned IDX_W = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             data_val_i,
   output logic             ready_o,
   output logic [WIDTH-1:0] data_left_o,
   output logic [WIDTH-1:0] data_right_o,
   output logic [IDX_W-1:0] left_idx_o,
   output logic [IDX_W-1:0] right_idx_o,
   output logic             zero_o,
   output logic             data_val_o
);

   localparam int unsigned NUM_SLICES = WIDTH / SLICE;
   localparam int unsigned K_W        = pos_w(NUM_SLICES);
   localparam int unsigned PW         = pos_w(SLICE);
   localparam logic [K_W-1:0] LAST_K  = K_W'(NUM_SLICES - 1);

   if (SLICE == 0 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
      $error("priority_encoder_seq: WIDTH must be a non-zero multiple of SLICE");
   end

   pe_state_t        state_q, state_d;
   logic [K_W-1:0]   k_q, k_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             found_q, found_d;
   logic [IDX_W-1:0] lidx_q, lidx_d;
   logic [IDX_W-1:0] ridx_q, ridx_d;

   logic             ready_q, ready_d;
   logic             val_q, val_d;
   logic [WIDTH-1:0] left_q, left_d;
   logic [WIDTH-1:0] right_q, right_d;
   logic [IDX_W-1:0] lidx_o_q, lidx_o_d;
   logic [IDX_W-1:0] ridx_o_q, ridx_o_d;
   logic             zero_q, zero_d;

   logic [SLICE-1:0] slice_sel;
   logic             slice_any;
   logic [PW-1:0]    slice_hi, slice_lo;
   logic [IDX_W-1:0] slice_base;
   logic             accept;

   assign slice_sel  = word_q[32'(k_q) * SLICE +: SLICE];
   assign slice_base = IDX_W'(32'(k_q) * SLICE);
   // ready_q is only ever set for IDLE and DONE, so it alone qualifies acceptance.
   assign accept     = data_val_i && ready_q;

   slice_prio #(.SLICE(SLICE)) u_slice (
      .slice_i  (slice_sel),
      .any_o    (slice_any),
      .hi_pos_o (slice_hi),
      .lo_pos_o (slice_lo)
   );

   always_ff @(posedge clk_i) begin
      if (srst_i)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SCAN;
         SCAN:    if (k_q == LAST_K) state_d = DONE;
         DONE:    state_d = accept ? SCAN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      k_d      = k_q;
      word_d   = word_q;
      found_d  = found_q;
      lidx_d   = lidx_q;
      ridx_d   = ridx_q;
      ready_d  = (state_d != SCAN);
      val_d    = (state_q == DONE);
      left_d   = left_q;
      right_d  = right_q;
      lidx_o_d = lidx_o_q;
      ridx_o_d = ridx_o_q;
      zero_d   = zero_q;

      if (state_q == SCAN) begin
         k_d = (k_q == LAST_K) ? '0 : k_q + K_W'(1);
         if (slice_any) begin
            lidx_d  = slice_base + IDX_W'(slice_hi);
            found_d = 1'b1;
            if (!found_q)
               ridx_d = slice_base + IDX_W'(slice_lo);
         end
      end

      if (state_q == DONE) begin
         left_d   = found_q ? (WIDTH'(1) << lidx_q) : '0;
         right_d  = found_q ? (WIDTH'(1) << ridx_q) : '0;
         lidx_o_d = lidx_q;
         ridx_o_d = ridx_q;
         zero_d   = !found_q;
      end

      if (accept) begin
         word_d  = data_i;
         k_d     = '0;
         found_d = 1'b0;
         lidx_d  = '0;
         ridx_d  = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         k_q      <= '0;
         word_q   <= '0;
         found_q  <= 1'b0;
         lidx_q   <= '0;
         ridx_q   <= '0;
         ready_q  <= 1'b1;
         val_q    <= 1'b0;
         left_q   <= '0;
         right_q  <= '0;
         lidx_o_q <= '0;
         ridx_o_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         k_q      <= k_d;
         word_q   <= word_d;
         found_q  <= found_d;
         lidx_q   <= lidx_d;
         ridx_q   <= ridx_d;
         ready_q  <= ready_d;
         val_q    <= val_d;
         left_q   <= left_d;
         right_q  <= right_d;
         lidx_o_q <= lidx_o_d;
         ridx_o_q <= ridx_o_d;
         zero_q   <= zero_d;
      end
   end

   assign ready_o      = ready_q;
   assign data_val_o   = val_q;
   assign data_left_o  = left_q;
   assign data_right_o = right_q;
   assign left_idx_o   = lidx_o_q;
   assign right_idx_o  = ridx_o_q;
   assign zero_o       = zero_q;

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Directed bench for priority_encoder_seq in three configurations.
module tb_priority_encoder_seq;

   logic clk = 1'b0;
   logic srst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // WIDTH=16, SLICE=4 (latency 5)
   logic [15:0] d_i = '0;
   logic        dv_i = 1'b0;
   logic        rdy, zero, dv_o;
   logic [15:0] left, right;
   logic [3:0]  lidx, ridx;

   priority_encoder_seq #(.WIDTH(16), .SLICE(4)) dut (
      .clk_i(clk), .srst_i(srst), .data_i(d_i), .data_val_i(dv_i), .ready_o(rdy),
      .data_left_o(left), .data_right_o(right), .left_idx_o(lidx), .right_idx_o(ridx),
      .zero_o(zero), .data_val_o(dv_o)
   );

   // WIDTH=16, SLICE=16 (latency 2)
   logic [15:0] s_d = '0;
   logic        s_dv = 1'b0;
   logic        s_rdy, s_zero, s_dvo;
   logic [15:0] s_left, s_right;
   logic [3:0]  s_lidx, s_ridx;

   priority_encoder_seq #(.WIDTH(16), .SLICE(16)) dut_s16 (
      .clk_i(clk), .srst_i(srst), .data_i(s_d), .data_val_i(s_dv), .ready_o(s_rdy),
      .data_left_o(s_left), .data_right_o(s_right), .left_idx_o(s_lidx), .right_idx_o(s_ridx),
      .zero_o(s_zero), .data_val_o(s_dvo)
   );

   // WIDTH=32, SLICE=8 (latency 5)
   logic [31:0] w_d = '0;
   logic        w_dv = 1'b0;
   logic        w_rdy, w_zero, w_dvo;
   logic [31:0] w_left, w_right;
   logic [4:0]  w_lidx, w_ridx;

   priority_encoder_seq #(.WIDTH(32), .SLICE(8)) dut_w32 (
      .clk_i(clk), .srst_i(srst), .data_i(w_d), .data_val_i(w_dv), .ready_o(w_rdy),
      .data_left_o(w_left), .data_right_o(w_right), .left_idx_o(w_lidx), .right_idx_o(w_ridx),
      .zero_o(w_zero), .data_val_o(w_dvo)
   );

   task automatic test_reset();
      srst = 1'b1;
      repeat (3) @(posedge clk);
      #1 srst = 1'b0;
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", rdy); end
      checks++; if (dv_o !== 1'b0) begin errors++; $display("FAIL reset_val: got %b exp 0", dv_o); end
      checks++; if (left !== 16'h0 || right !== 16'h0) begin errors++; $display("FAIL reset_masks: got %h/%h exp 0/0", left, right); end
      checks++; if (lidx !== 4'd0 || ridx !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d/%0d exp 0/0", lidx, ridx); end
      checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b exp 0", zero); end
      checks++; if (s_rdy !== 1'b1 || w_rdy !== 1'b1) begin errors++; $display("FAIL reset_ready_alt: got %b/%b exp 1/1", s_rdy, w_rdy); end
   endtask

   task automatic test_encode(input string name, input logic [15:0] word,
                              input logic [15:0] exp_l, input logic [15:0] exp_r,
                              input logic [3:0] exp_li, input logic [3:0] exp_ri, input logic exp_z);
      @(negedge clk);
      d_i = word; dv_i = 1'b1;
      @(posedge clk);
      #1 dv_i = 1'b0;
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL %s_busy: got ready %b exp 0", name, rdy); end
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         checks++;
         if (dv_o !== (c == 5)) begin errors++; $display("FAIL %s_lat%0d: got val %b exp %b", name, c, dv_o, (c == 5)); end
      end
      checks++; if (left !== exp_l) begin errors++; $display("FAIL %s_left: got %h exp %h", name, left, exp_l); end
      checks++; if (right !== exp_r) begin errors++; $display("FAIL %s_right: got %h exp %h", name, right, exp_r); end
      checks++; if (lidx !== exp_li) begin errors++; $display("FAIL %s_lidx: got %0d exp %0d", name, lidx, exp_li); end
      checks++; if (ridx !== exp_ri) begin errors++; $display("FAIL %s_ridx: got %0d exp %0d", name, ridx, exp_ri); end
      checks++; if (zero !== exp_z) begin errors++; $display("FAIL %s_zero: got %b exp %b", name, zero, exp_z); end
      @(posedge clk); #1;
      checks++; if (dv_o !== 1'b0) begin errors++; $display("FAIL %s_pulse: got val %b exp 0", name, dv_o); end
      checks++; if (left !== exp_l || lidx !== exp_li || zero !== exp_z) begin
         errors++; $display("FAIL %s_hold: got %h/%0d/%b exp %h/%0d/%b", name, left, lidx, zero, exp_l, exp_li, exp_z);
      end
   endtask

   task automatic test_ignore_busy();
      @(negedge clk);
      d_i = 16'h0810; dv_i = 1'b1;
      @(posedge clk);
      #1 d_i = 16'hFFFF;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1;
         checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL ignore_ready%0d: got %b exp 0", c, rdy); end
      end
      dv_i = 1'b0;
      @(posedge clk); #1;
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL ignore_done_ready: got %b exp 1", rdy); end
      @(posedge clk); #1;
      checks++; if (dv_o !== 1'b1) begin errors++; $display("FAIL ignore_val: got %b exp 1", dv_o); end
      checks++; if (lidx !== 4'd11 || ridx !== 4'd4) begin errors++; $display("FAIL ignore_idx: got %0d/%0d exp 11/4", lidx, ridx); end
      checks++; if (left !== 16'h0800 || right !== 16'h0010) begin errors++; $display("FAIL ignore_masks: got %h/%h exp 0800/0010", left, right); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [15:0] w [0:10];
      logic exp_v, exp_r;
      w[0] = 16'h00F0;
      for (int t = 1; t <= 4; t++) w[t] = 16'hFFFF;
      w[5] = 16'h1000;
      for (int t = 6; t <= 9; t++) w[t] = 16'h0001;
      w[10] = 16'h0300;
      for (int t = 0; t <= 10; t++) begin
         @(negedge clk);
         d_i = w[t]; dv_i = 1'b1;
         @(posedge clk); #1;
         exp_v = (t == 5) || (t == 10);
         exp_r = ((t % 5) == 4);
         checks++; if (dv_o !== exp_v) begin errors++; $display("FAIL b2b_val_t%0d: got %b exp %b", t, dv_o, exp_v); end
         checks++; if (rdy !== exp_r) begin errors++; $display("FAIL b2b_ready_t%0d: got %b exp %b", t, rdy, exp_r); end
         if (t == 5) begin
            checks++; if (lidx !== 4'd7 || ridx !== 4'd4 || left !== 16'h0080 || right !== 16'h0010) begin
               errors++; $display("FAIL b2b_word0: got %h/%h %0d/%0d exp 0080/0010 7/4", left, right, lidx, ridx);
            end
         end
         if (t == 10) begin
            checks++; if (lidx !== 4'd12 || ridx !== 4'd12 || left !== 16'h1000 || right !== 16'h1000) begin
               errors++; $display("FAIL b2b_word5: got %h/%h %0d/%0d exp 1000/1000 12/12", left, right, lidx, ridx);
            end
         end
      end
      dv_i = 1'b0;
      for (int t = 11; t <= 15; t++) begin
         @(posedge clk); #1;
         checks++; if (dv_o !== (t == 15)) begin errors++; $display("FAIL b2b_val_t%0d: got %b exp %b", t, dv_o, (t == 15)); end
      end
      checks++; if (lidx !== 4'd9 || ridx !== 4'd8 || left !== 16'h0200 || right !== 16'h0100 || zero !== 1'b0) begin
         errors++; $display("FAIL b2b_word10: got %h/%h %0d/%0d z%b exp 0200/0100 9/8 z0", left, right, lidx, ridx, zero);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_scan();
      @(negedge clk);
      d_i = 16'hFFFF; dv_i = 1'b1;
      @(posedge clk);
      #1 dv_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 srst = 1'b1;
      @(posedge clk);
      #1 srst = 1'b0;
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b exp 1", rdy); end
      checks++; if (left !== 16'h0 || right !== 16'h0 || lidx !== 4'd0 || ridx !== 4'd0 || zero !== 1'b0) begin
         errors++; $display("FAIL midrst_outputs: got %h/%h %0d/%0d z%b exp all 0", left, right, lidx, ridx, zero);
      end
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         checks++; if (dv_o !== 1'b0 || rdy !== 1'b1) begin
            errors++; $display("FAIL midrst_quiet%0d: got val %b ready %b exp 0/1", c, dv_o, rdy);
         end
      end
      test_encode("after_rst", 16'h0810, 16'h0800, 16'h0010, 4'd11, 4'd4, 1'b0);
   endtask

   task automatic enc_s16(input string name, input logic [15:0] word, input logic [15:0] exp_l,
                          input logic [15:0] exp_r, input logic [3:0] exp_li, input logic [3:0] exp_ri,
                          input logic exp_z);
      @(negedge clk);
      s_d = word; s_dv = 1'b1;
      @(posedge clk);
      #1 s_dv = 1'b0;
      @(posedge clk); #1;
      checks++; if (s_dvo !== 1'b0) begin errors++; $display("FAIL %s_early: got val %b exp 0", name, s_dvo); end
      @(posedge clk); #1;
      checks++; if (s_dvo !== 1'b1) begin errors++; $display("FAIL %s_val: got %b exp 1", name, s_dvo); end
      checks++; if (s_left !== exp_l || s_right !== exp_r || s_lidx !== exp_li || s_ridx !== exp_ri || s_zero !== exp_z) begin
         errors++; $display("FAIL %s_result: got %h/%h %0d/%0d z%b exp %h/%h %0d/%0d z%b",
                            name, s_left, s_right, s_lidx, s_ridx, s_zero, exp_l, exp_r, exp_li, exp_ri, exp_z);
      end
      @(posedge clk); #1;
   endtask

   task automatic enc_w32(input string name, input logic [31:0] word, input logic [31:0] exp_l,
                          input logic [31:0] exp_r, input logic [4:0] exp_li, input logic [4:0] exp_ri);
      @(negedge clk);
      w_d = word; w_dv = 1'b1;
      @(posedge clk);
      #1 w_dv = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         checks++; if (w_dvo !== (c == 5)) begin errors++; $display("FAIL %s_lat%0d: got val %b exp %b", name, c, w_dvo, (c == 5)); end
      end
      checks++; if (w_left !== exp_l || w_right !== exp_r || w_lidx !== exp_li || w_ridx !== exp_ri || w_zero !== 1'b0) begin
         errors++; $display("FAIL %s_result: got %h/%h %0d/%0d z%b exp %h/%h %0d/%0d z0",
                            name, w_left, w_right, w_lidx, w_ridx, w_zero, exp_l, exp_r, exp_li, exp_ri);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_slice16();
      enc_s16("s16_0810", 16'h0810, 16'h0800, 16'h0010, 4'd11, 4'd4, 1'b0);
      enc_s16("s16_zero", 16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b1);
      enc_s16("s16_8001", 16'h8001, 16'h8000, 16'h0001, 4'd15, 4'd0, 1'b0);
   endtask

   task automatic test_wide32();
      enc_w32("w32_split", 32'h8000_0002, 32'h8000_0000, 32'h0000_0002, 5'd31, 5'd1);
      enc_w32("w32_single", 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 5'd16, 5'd16);
      enc_w32("w32_mid", 32'h0024_8000, 32'h0020_0000, 32'h0000_8000, 5'd21, 5'd15);
   endtask

   initial begin
      test_reset();
      test_encode("basic", 16'h0810, 16'h0800, 16'h0010, 4'd11, 4'd4, 1'b0);
      test_encode("zero", 16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b1);
      test_encode("ends", 16'h8001, 16'h8000, 16'h0001, 4'd15, 4'd0, 1'b0);
      test_encode("single", 16'h0040, 16'h0040, 16'h0040, 4'd6, 4'd6, 1'b0);
      test_encode("lsb_only", 16'h0001, 16'h0001, 16'h0001, 4'd0, 4'd0, 1'b0);
      test_encode("all_ones", 16'hFFFF, 16'h8000, 16'h0001, 4'd15, 4'd0, 1'b0);
      test_encode("in_slice", 16'h0A00, 16'h0800, 16'h0200, 4'd11, 4'd9, 1'b0);
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid_scan();
      test_slice16();
      test_wide32();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
